// File: rtl/mips_stage_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mips_stage_mem                                              |
// | Description : MIPS pipeline memory stage. Unpacks ExMem, issues loads and |
// |               stores on a request/ready data-memory port, stalls upstream |
// |               while an access is outstanding and builds the MemWb bundle. |
// |               Generates byte enables, store lane replication, load lane   |
// |               extraction with sign/zero extension, misalignment faults    |
// |               and a watchdog on every access.                             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                     |
// |   i_ctrl        clock + synchronous active-low reset                       |
// |   i_pipeExMem   instruction, pcAddr, control, regPort2, aluResult from EX  |
// |   o_pipeMemWb   instruction, pcAddr, control, aluResult, memData, fault    |
// |   o_stallUp     holds IF/ID/EX and the ExMem register                      |
// |   o_memReq      access request valid                                       |
// |   o_memWe       1 = store                                                  |
// |   o_memAddr     word-aligned address                                       |
// |   o_memByteEn   lane enables                                               |
// |   o_memWData    store data replicated into lanes                           |
// |   i_memRData    load data, valid with i_memReady                           |
// |   i_memReady    access completes this cycle                                |
// +--------------------------------------------------------------------------+

package mips_stage_mem_pkg;
   typedef struct packed {
      logic clk;
      logic resetN;
   } Data_Control_Control_T;

   typedef struct packed {
      logic       regWrite;
      logic       memToReg;
      logic       memRead;
      logic       memWrite;
      logic [1:0] memSize;    // 00 byte, 01 half, 10 word
      logic       memSigned;
   } Mips_Control_T;

   typedef struct packed {
      logic [31:0]   instruction;
      logic [31:0]   pcAddr;
      Mips_Control_T control;
      logic [31:0]   regPort2;
      logic [31:0]   aluResult;
   } Mips_Pipeline_ExMem_T;

   typedef struct packed {
      logic [31:0]   instruction;
      logic [31:0]   pcAddr;
      Mips_Control_T control;
      logic [31:0]   aluResult;
      logic [31:0]   memData;
      logic          fault;
   } Mips_Pipeline_MemWb_T;

   localparam logic [1:0] c_SIZE_BYTE = 2'b00;
   localparam logic [1:0] c_SIZE_HALF = 2'b01;
endpackage

module mips_stage_mem
   import mips_stage_mem_pkg::*;
#(
   parameter bit          DELAYED    = 1'b1,
   parameter int unsigned TIMEOUT    = 255,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  Data_Control_Control_T i_ctrl,
   input  Mips_Pipeline_ExMem_T  i_pipeExMem,
   output Mips_Pipeline_MemWb_T  o_pipeMemWb,
   output logic                  o_stallUp,
   output logic                  o_memReq,
   output logic                  o_memWe,
   output logic [31:0]           o_memAddr,
   output logic [3:0]            o_memByteEn,
   output logic [31:0]           o_memWData,
   input  logic [31:0]           i_memRData,
   input  logic                  i_memReady
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   logic w_clk;
   logic w_rstN;
   assign w_clk  = i_ctrl.clk;
   assign w_rstN = i_ctrl.resetN;

   // Byte-lane helpers. Big-endian mirrors the little-endian enable mask.
   function automatic logic [3:0] f_byteEn(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] m;
      case (size)
         c_SIZE_BYTE: m = 4'b0001 << a;
         c_SIZE_HALF: m = 4'b0011 << a;
         default:     m = 4'b1111;
      endcase
      if (BIG_ENDIAN) m = {m[0], m[1], m[2], m[3]};
      return m;
   endfunction

   // Lowest enabled lane: the byte that ends up at bit 0 of a load.
   function automatic logic [1:0] f_lane(input logic [1:0] size, input logic [1:0] a);
      case (size)
         c_SIZE_BYTE: return BIG_ENDIAN ? 2'd3 - a : a;
         c_SIZE_HALF: return BIG_ENDIAN ? 2'd2 - a : a;
         default:     return 2'd0;
      endcase
   endfunction

   function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
      case (size)
         c_SIZE_BYTE: return {4{d[7:0]}};
         c_SIZE_HALF: return {2{d[15:0]}};
         default:     return d;
      endcase
   endfunction

   function automatic logic [31:0] f_load(input logic [1:0] size, input logic sgn,
                                          input logic [1:0] lane, input logic [31:0] rd);
      logic [31:0] s;
      s = rd >> {lane, 3'b000};
      case (size)
         c_SIZE_BYTE: return {{24{sgn & s[7]}}, s[7:0]};
         c_SIZE_HALF: return {{16{sgn & s[15]}}, s[15:0]};
         default:     return s;
      endcase
   endfunction

   state_t               r_state;
   state_t               w_stateNext;
   Mips_Pipeline_ExMem_T r_ex;        // latched copy of the access in flight
   logic [31:0]          r_memData;
   logic                 r_fault;
   logic [7:0]           r_cnt;
   Mips_Pipeline_MemWb_T w_wb;

   // Decode of the live ExMem entry (only meaningful in IDLE).
   logic w_isMem;
   logic w_misalign;
   logic w_valid;
   assign w_isMem    = i_pipeExMem.control.memRead | i_pipeExMem.control.memWrite;
   assign w_misalign = ((i_pipeExMem.control.memSize == c_SIZE_HALF) && i_pipeExMem.aluResult[0]) ||
                       (i_pipeExMem.control.memSize[1] && (i_pipeExMem.aluResult[1:0] != 2'b00));
   assign w_valid    = w_isMem & ~w_misalign;

   // The request is driven straight from ExMem in its first cycle and from
   // the latched copy afterwards, so the bus stays stable until ready.
   logic        w_fromLive;
   logic [1:0]  w_size;
   logic        w_signed;
   logic        w_read;
   logic        w_write;
   logic [31:0] w_alu;
   logic [31:0] w_data;
   logic [31:0] w_load;
   assign w_fromLive = (r_state == S_IDLE);
   assign w_size     = w_fromLive ? i_pipeExMem.control.memSize   : r_ex.control.memSize;
   assign w_signed   = w_fromLive ? i_pipeExMem.control.memSigned : r_ex.control.memSigned;
   assign w_read     = w_fromLive ? i_pipeExMem.control.memRead   : r_ex.control.memRead;
   assign w_write    = w_fromLive ? i_pipeExMem.control.memWrite  : r_ex.control.memWrite;
   assign w_alu      = w_fromLive ? i_pipeExMem.aluResult         : r_ex.aluResult;
   assign w_data     = w_fromLive ? i_pipeExMem.regPort2          : r_ex.regPort2;
   assign w_load     = w_read ? f_load(w_size, w_signed, f_lane(w_size, w_alu[1:0]), i_memRData)
                              : 32'd0;

   // Watchdog fires in the ACCESS cycle where the wait count reaches TIMEOUT.
   logic w_timeout;
   assign w_timeout = (TIMEOUT != 0) && ((r_cnt + 8'd1) == 8'(TIMEOUT));

   always_ff @(posedge w_clk) begin
      if (!w_rstN) r_state <= S_IDLE;
      else         r_state <= w_stateNext;
   end

   always_comb begin
      logic w_drive;
      w_drive     = 1'b0;
      w_stateNext = r_state;
      o_stallUp   = 1'b0;
      o_memReq    = 1'b0;
      o_memWe     = 1'b0;
      o_memAddr   = 32'd0;
      o_memByteEn = 4'd0;
      o_memWData  = 32'd0;
      w_wb        = '0;   // bubble while stalled
      case (r_state)
         S_IDLE: begin
            if (w_valid) begin
               o_stallUp = 1'b1;
               w_drive   = 1'b1;
               // A slave answering in the request cycle skips ACCESS.
               w_stateNext = i_memReady ? S_DONE : S_ACCESS;
            end else begin
               w_wb.instruction = i_pipeExMem.instruction;
               w_wb.pcAddr      = i_pipeExMem.pcAddr;
               w_wb.control     = i_pipeExMem.control;
               w_wb.aluResult   = i_pipeExMem.aluResult;
               w_wb.fault       = w_isMem;   // memory op here means misaligned
            end
         end
         S_ACCESS: begin
            o_stallUp = 1'b1;
            w_drive   = 1'b1;
            if (i_memReady || w_timeout) w_stateNext = S_DONE;
         end
         S_DONE: begin
            w_wb.instruction = r_ex.instruction;
            w_wb.pcAddr      = r_ex.pcAddr;
            w_wb.control     = r_ex.control;
            w_wb.aluResult   = r_ex.aluResult;
            w_wb.memData     = r_memData;
            w_wb.fault       = r_fault;
            w_stateNext      = S_IDLE;
         end
         default: w_stateNext = S_IDLE;
      endcase
      if (w_drive) begin
         o_memReq    = 1'b1;
         o_memWe     = w_write;
         o_memAddr   = {w_alu[31:2], 2'b00};
         o_memByteEn = f_byteEn(w_size, w_alu[1:0]);
         o_memWData  = f_wdata(w_size, w_data);
      end
   end

   always_ff @(posedge w_clk) begin
      if (!w_rstN) begin
         r_ex      <= '0;
         r_memData <= 32'd0;
         r_fault   <= 1'b0;
         r_cnt     <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_ex      <= i_pipeExMem;
                  r_cnt     <= 8'd0;
                  r_memData <= w_load;
                  r_fault   <= 1'b0;
               end
            end
            S_ACCESS: begin
               // Ready wins over a simultaneous watchdog expiry.
               if (i_memReady) begin
                  r_memData <= w_load;
                  r_fault   <= 1'b0;
               end else if (w_timeout) begin
                  r_memData <= 32'd0;
                  r_fault   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   generate
      if (DELAYED) begin : g_delayed
         Mips_Pipeline_MemWb_T r_wb;
         always_ff @(posedge w_clk) begin
            if (!w_rstN) r_wb <= '0;
            else         r_wb <= w_wb;
         end
         assign o_pipeMemWb = r_wb;
      end else begin : g_comb
         assign o_pipeMemWb = w_wb;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mips_stage_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mips_stage_mem                                           |
// | Description : Self-checking bench for mips_stage_mem: directed accesses,  |
// |               watchdog and reset cases, then randomized accesses checked  |
// |               against a byte-level reference model.                       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mips_stage_mem;
   import mips_stage_mem_pkg::*;

   localparam int TO = 4;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   Data_Control_Control_T ctrl;
   assign ctrl = '{clk: clk, resetN: rstN};

   Mips_Pipeline_ExMem_T ex;
   Mips_Pipeline_MemWb_T wb;
   logic        stall, req, we, ready;
   logic [31:0] addr, wdat, rdata;
   logic [3:0]  be;

   int tests = 0;
   int fails = 0;

   mips_stage_mem #(.DELAYED(1'b1), .TIMEOUT(TO), .BIG_ENDIAN(1'b0)) dut (
      .i_ctrl      (ctrl),
      .i_pipeExMem (ex),
      .o_pipeMemWb (wb),
      .o_stallUp   (stall),
      .o_memReq    (req),
      .o_memWe     (we),
      .o_memAddr   (addr),
      .o_memByteEn (be),
      .o_memWData  (wdat),
      .i_memRData  (rdata),
      .i_memReady  (ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference: memory seen as four byte lanes, lane i = address offset i.
   function automatic void model(input logic [1:0] size, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] data,
                                 input logic [31:0] rd, output logic mis,
                                 output logic [3:0] xbe, output logic [31:0] xwd,
                                 output logic [31:0] xld);
      int n, off;
      logic [63:0] v;
      n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off = int'(a[1:0]);
      mis = (off % n) != 0;
      xbe = '0; xwd = '0; v = '0;
      for (int i = 0; i < 4; i++) xwd[8*i +: 8] = data[8*(i % n) +: 8];
      if (!mis) begin
         for (int k = 0; k < n; k++) begin
            xbe[off + k]  = 1'b1;
            v[8*k +: 8]   = rd[8*(off + k) +: 8];
         end
      end
      if (sgn && v[8*n - 1]) v = v | (~64'd0 << (8*n));
      xld = v[31:0];
   endfunction

   function automatic Mips_Pipeline_ExMem_T mk(input logic [31:0] instr, input logic rd,
                                               input logic wr, input logic [1:0] sz,
                                               input logic sg, input logic [31:0] a,
                                               input logic [31:0] d);
      Mips_Pipeline_ExMem_T e;
      e = '0;
      e.instruction       = instr;
      e.pcAddr            = {instr[27:0], 4'h4};
      e.control.regWrite  = rd;
      e.control.memToReg  = rd;
      e.control.memRead   = rd;
      e.control.memWrite  = wr;
      e.control.memSize   = sz;
      e.control.memSigned = sg;
      e.regPort2          = d;
      e.aluResult         = a;
      return e;
   endfunction

   // Called at #1 after a rising edge; returns at #1 after a rising edge.
   // readyAt: 0 = ready in the request cycle, k = k-th wait cycle, -1 = never.
   task automatic run(input Mips_Pipeline_ExMem_T e, input int readyAt,
                      input logic [31:0] rd, input string nm);
      logic        mis, isMem, xfault;
      logic [3:0]  xbe;
      logic [31:0] xwd, xld, xmem;
      int          kEnd;
      model(e.control.memSize, e.control.memSigned, e.aluResult, e.regPort2, rd,
            mis, xbe, xwd, xld);
      isMem = e.control.memRead | e.control.memWrite;
      ex = e; rdata = rd; ready = (readyAt == 0);
      @(negedge clk);
      if (!isMem || mis) begin
         chk({nm, " stall"}, 32'(stall), 32'd0);
         chk({nm, " req"}, 32'(req), 32'd0);
         @(posedge clk); #1; ex = '0; ready = 1'b0;
         @(negedge clk);
         chk({nm, " wb.instr"}, wb.instruction, e.instruction);
         chk({nm, " wb.alu"}, wb.aluResult, e.aluResult);
         chk({nm, " wb.ctl"}, 32'(wb.control), 32'(e.control));
         chk({nm, " wb.memData"}, wb.memData, 32'd0);
         chk({nm, " wb.fault"}, 32'(wb.fault), 32'(isMem));
         @(posedge clk); #1;
         return;
      end
      chk({nm, " stall0"}, 32'(stall), 32'd1);
      chk({nm, " req0"}, 32'(req), 32'd1);
      chk({nm, " we"}, 32'(we), 32'(e.control.memWrite));
      chk({nm, " addr"}, addr, {e.aluResult[31:2], 2'b00});
      chk({nm, " be"}, 32'(be), 32'(xbe));
      chk({nm, " wdata"}, wdat, xwd);
      if (readyAt >= 0 && readyAt <= TO) begin kEnd = readyAt; xfault = 1'b0; end
      else begin kEnd = TO; xfault = 1'b1; end
      for (int k = 1; k <= kEnd + 1; k++) begin
         @(posedge clk); #1; ready = (readyAt == k);
         @(negedge clk);
         chk({nm, " bubble"}, wb.instruction, 32'd0);
         if (k <= kEnd) begin
            chk({nm, " req hold"}, 32'(req), 32'd1);
            chk({nm, " stall hold"}, 32'(stall), 32'd1);
            chk({nm, " be hold"}, 32'(be), 32'(xbe));
            chk({nm, " wdata hold"}, wdat, xwd);
         end else begin
            chk({nm, " done stall"}, 32'(stall), 32'd0);
            chk({nm, " done req"}, 32'(req), 32'd0);
         end
      end
      @(posedge clk); #1; ex = '0; ready = 1'b0;
      @(negedge clk);
      xmem = (xfault || !e.control.memRead) ? 32'd0 : xld;
      chk({nm, " wb.instr"}, wb.instruction, e.instruction);
      chk({nm, " wb.pc"}, wb.pcAddr, e.pcAddr);
      chk({nm, " wb.memData"}, wb.memData, xmem);
      chk({nm, " wb.fault"}, 32'(wb.fault), 32'(xfault));
      @(posedge clk); #1;
   endtask

   initial begin
      ex = '0; ready = 1'b0; rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst req", 32'(req), 32'd0);
      chk("rst we", 32'(we), 32'd0);
      chk("rst be", 32'(be), 32'd0);
      chk("rst addr", addr, 32'd0);
      chk("rst wdata", wdat, 32'd0);
      chk("rst wb.instr", wb.instruction, 32'd0);
      chk("rst wb.fault", 32'(wb.fault), 32'd0);
      @(posedge clk); #1;

      run(mk(32'h8C41_0000, 1, 0, 2'd2, 0, 32'h100, 32'h0), 2, 32'hDEAD_BEEF, "lw");
      run(mk(32'h8041_0003, 1, 0, 2'd0, 1, 32'h103, 32'h0), 1, 32'h8012_3456, "lb");
      run(mk(32'h9041_0003, 1, 0, 2'd0, 0, 32'h103, 32'h0), 1, 32'h8012_3456, "lbu");
      run(mk(32'hA441_0002, 0, 1, 2'd1, 0, 32'h102, 32'h0000_ABCD), 0, 32'h0, "sh");
      run(mk(32'h8C41_0001, 1, 0, 2'd2, 0, 32'h101, 32'h0), 0, 32'h1234_5678, "lw mis");
      run(mk(32'h0022_1820, 0, 0, 2'd0, 0, 32'h55AA, 32'h0), 0, 32'h0, "alu");
      run(mk(32'h8C41_0200, 1, 0, 2'd2, 0, 32'h200, 32'h0), -1, 32'hCAFE_F00D, "lw tmo");
      run(mk(32'h8C41_0204, 1, 0, 2'd2, 0, 32'h204, 32'h0), TO, 32'hCAFE_F00D, "lw edge");
      run(mk(32'h8441_0006, 1, 0, 2'd1, 1, 32'h206, 32'h0), 5, 32'h9ABC_1234, "lh late");

      for (int i = 0; i < 40; i++) begin
         logic [1:0] sz;
         int op, ra;
         sz = 2'($urandom_range(0, 2));
         op = int'($urandom_range(0, 4));
         ra = int'($urandom_range(0, 7)) - 1;
         run(mk($urandom, (op == 1 || op == 2), (op >= 3), sz, 1'($urandom_range(0, 1)),
                $urandom, $urandom), ra, $urandom, "rand");
      end

      // Reset in the middle of an access, then a stray ready.
      ex = mk(32'h8C41_0300, 1, 0, 2'd2, 0, 32'h300, 32'h0); ready = 1'b0;
      @(negedge clk);
      chk("mid req", 32'(req), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid stall", 32'(stall), 32'd1);
      rstN = 1'b0; ex = '0;
      @(posedge clk); #1;
      rstN = 1'b1; ready = 1'b1; rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("rst-acc req", 32'(req), 32'd0);
      chk("rst-acc stall", 32'(stall), 32'd0);
      chk("rst-acc wb.instr", wb.instruction, 32'd0);
      @(posedge clk); #1; ready = 1'b0;
      @(negedge clk);
      chk("late rdy wb.instr", wb.instruction, 32'd0);
      chk("late rdy wb.memData", wb.memData, 32'd0);
      chk("late rdy wb.fault", 32'(wb.fault), 32'd0);
      chk("late rdy req", 32'(req), 32'd0);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mips_stage_mem.md
Name: mips_stage_mem

Overview:
Memory stage of the pipelined MIPS core. It is the consumer end of the ExMem pipeline register. It unpacks ExMem, performs loads and stores against the data-memory request/ready interface, stalls upstream while an access is outstanding, and produces the MemWb pipeline bundle for writeback. Byte lanes are aligned, byte enables and sign/zero extension are generated, misalignment is detected and a watchdog bounds every access.

Parameters:
DELAYED, 1, 1 = MemWb bundle registered (one-cycle stage latency); 0 = MemWb driven combinationally from the DONE-path values
TIMEOUT, 255, max cycles waiting for memReady before fault; 8-bit counter; 0 disables the watchdog
BIG_ENDIAN, 0, byte-lane order for sub-word accesses

Ports:
ctrl  input  Data_Control_Control_T  clock and reset; reset is synchronous, active-low
pipeExMem  input  Mips_Pipeline_ExMem_T  instruction, pcAddr, control, regPort2, aluResult from EX
pipeMemWb  output  Mips_Pipeline_MemWb_T  instruction, pcAddr, control, aluResult, memData, fault
stallUp  output  1  holds IF/ID/EX and the ExMem register
memReq  output  1  access request valid
memWe  output  1  1 = store
memAddr  output  32  word-aligned address (aluResult[31:2],2'b00)
memByteEn  output  4  lane enables
memWData  output  32  store data replicated/shifted into lanes
memRData  input  32  load data, valid when memReady
memReady  input  1  access complete this cycle

Behaviour:
- Access type comes from the control fields memRead, memWrite, memSize (00 byte, 01 half, 10 word) and memSigned. Neither flag set = pass-through.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - pass-through or nop -> MemWb captures the fields next edge; stallUp=0.
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> no memReq; MemWb fault=1, memData=0; stays IDLE.
  - valid access -> ACCESS; memReq=1 in the same cycle, combinationally from ExMem; stallUp=1.
- ACCESS:
  - memReq, memWe, memAddr, memByteEn and memWData are held stable from the latched copy until memReady.
  - memReady=1 -> capture aligned/extended load data -> DONE.
  - watchdog: the counter clears on entry and increments each cycle without memReady. Count==TIMEOUT -> drop memReq, fault=1, -> DONE.
  - memReady in the same cycle the counter reaches TIMEOUT: ready wins, no fault.
- DONE: stallUp=0; MemWb takes the captured result at this edge; -> IDLE. The next ExMem entry is evaluated in the following cycle. A back-to-back access therefore costs at least 2 cycles.
- Byte enables (little-endian):
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - BIG_ENDIAN mirrors the lane index (3-addr[1:0]).
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- Load data: selected lane shifted to bit 0, then sign- or zero-extended to 32 bits per memSigned.
- stallUp = (state==IDLE && valid access) || state==ACCESS.
- Reset (ctrl reset low at an edge):
  - state=IDLE, counter=0, memReq=0, memWe=0, memByteEn=0, memAddr=0, memWData=0, stallUp=0.
  - MemWb all-zero (nop instruction, control=0, fault=0).
  - Reset during ACCESS abandons the access; a memReady arriving afterwards is ignored.
- A new ExMem value is never sampled while stallUp=1, because upstream holds it.

Test Plan:
- lw addr 0x100, memReady after 3 cycles with memRData=0xDEADBEEF -> memReq high 3 cycles, byteEn 1111, stallUp high until DONE, MemWb.memData=0xDEADBEEF one cycle later.
- lb signed addr 0x103, memRData=0x80123456 (LE) -> byteEn 1000, memData=0xFFFFFF80; lbu -> 0x00000080.
- sh addr 0x102 data 0x0000ABCD, memReady immediate -> memWe=1, byteEn 1100, memWData=0xABCDABCD, stall 1 cycle plus DONE.
- lw addr 0x101 -> no memReq, fault=1, stallUp never asserted.
- TIMEOUT=4, memReady held low -> memReq drops after 4 cycles, fault=1, pipeline resumes; repeat with memReady on cycle 4 -> no fault.
- Reset low mid-ACCESS -> next cycle memReq=0, stallUp=0, MemWb zero; a late memReady has no effect.
